mu0_sequencer: RTL and testbench

Control sequencer for the MU0/ARM-extension CPU. Steps each instruction through FETCH, EXEC1 and optional EXEC2, runs a req/ack handshake with the memory port, and drives the one-cycle `exec1`/`exec2` timing strobes consumed by the ALU and register file. It also generates the PC, IR and ACC enables, implements skip suppression and STP halt, and counts retired instructions.

---
 rtl/mu0_sequencer_if.sv | 9 +
 rtl/mu0_sequencer.sv | 87 ++++++++
 tb/tb_mu0_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mu0_sequencer_if.sv
// mu0_sequencer_if: memory-port handshake between the sequencer and memory.
interface mu0_sequencer_if;
    logic mem_req;
    logic mem_wr;
    logic addr_sel;
    logic mem_ack;
    modport master (output mem_req, output mem_wr, output addr_sel, input mem_ack);
    modport slave (input mem_req, input mem_wr, input addr_sel, output mem_ack);
endinterface

// File: rtl/mu0_sequencer.sv
// mu0_sequencer: FETCH/EXEC1/EXEC2 control sequencer with memory handshake, skip and halt.
module mu0_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [15:0]      instruction,
    input  logic             skipstatus,
    input  logic             acc_zero,
    input  logic             acc_neg,
    mu0_sequencer_if.master  mem,
    output logic             ir_en,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             acc_en,
    output logic             exec1,
    output logic             exec2,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC1, EXEC2, HALT} state_t;
    state_t state, next;
    logic skip_r;
    logic [3:0] op;
    logic is_mem, is_rd, is_acc, retire;
    assign op = instruction[15:12];
    assign is_mem = op[3:2] == 2'b00;
    assign is_rd = is_mem && op != 4'h1;
    assign is_acc = op == 4'h8 || op == 4'h9 || op == 4'hA;
    // Retirement: EXEC2 for reads, otherwise the completing EXEC1 cycle.
    assign retire = exec2 || (exec1 && !is_rd);
    assign halted = state == HALT;
    always_comb begin
        next = state;
        mem.mem_req = 1'b0;
        mem.mem_wr = 1'b0;
        mem.addr_sel = 1'b0;
        ir_en = 1'b0;
        pc_inc = 1'b0;
        pc_load = 1'b0;
        acc_en = 1'b0;
        exec1 = 1'b0;
        exec2 = 1'b0;
        case (state)
            IDLE, HALT: next = start ? FETCH : state;
            FETCH: begin
                mem.mem_req = 1'b1;
                ir_en = mem.mem_ack;
                pc_inc = mem.mem_ack;
                next = mem.mem_ack ? EXEC1 : FETCH;
            end
            EXEC1: begin
                if (is_mem) begin
                    // A skipped memory access finishes at once and ignores ack.
                    mem.mem_req = !skip_r;
                    mem.addr_sel = !skip_r;
                    mem.mem_wr = !skip_r && op == 4'h1;
                    exec1 = skip_r || mem.mem_ack;
                    next = !exec1 ? EXEC1 : is_rd ? EXEC2 : FETCH;
                end else begin
                    exec1 = 1'b1;
                    pc_load = !skip_r && (op == 4'h4 || (op == 4'h5 && acc_neg) || (op == 4'h6 && acc_zero));
                    acc_en = !skip_r && is_acc;
                    next = (op == 4'h7 && !skip_r) ? HALT : FETCH;
                end
            end
            EXEC2: begin
                exec2 = 1'b1;
                acc_en = !skip_r;
                next = FETCH;
            end
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            skip_r <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next;
            if (state == FETCH && mem.mem_ack) skip_r <= skipstatus;
            instr_count <= instr_count + CNT_W'(retire);
        end
    end
endmodule

// File: tb/tb_mu0_sequencer.sv
// tb_mu0_sequencer: scoreboard bench driving instruction streams and comparing per-cycle strobes.
module tb_mu0_sequencer;
    localparam int CW = 8;
    localparam logic [9:0] REQ = 10'h200, WR = 10'h100, AS = 10'h080, IR = 10'h040, PCI = 10'h020;
    localparam logic [9:0] PL = 10'h010, AE = 10'h008, E1 = 10'h004, E2 = 10'h002, HL = 10'h001;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic [15:0] instruction = 16'h0;
    logic skipstatus = 1'b0;
    logic acc_zero = 1'b0;
    logic acc_neg = 1'b0;
    logic ir_en, pc_inc, pc_load, acc_en, exec1, exec2, halted;
    logic [CW-1:0] instr_count;
    logic [CW-1:0] exp_cnt = '0;
    logic [9:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    mu0_sequencer_if bus ();
    mu0_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .instruction(instruction),
        .skipstatus(skipstatus), .acc_zero(acc_zero), .acc_neg(acc_neg), .mem(bus.master),
        .ir_en(ir_en), .pc_inc(pc_inc), .pc_load(pc_load), .acc_en(acc_en),
        .exec1(exec1), .exec2(exec2), .halted(halted), .instr_count(instr_count)
    );
    always #5 clk = ~clk;
    function automatic logic [9:0] outs();
        return {bus.mem_req, bus.mem_wr, bus.addr_sel, ir_en, pc_inc, pc_load, acc_en, exec1, exec2, halted};
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // Called just after a rising edge: drive ack, compare at the falling edge, advance one cycle.
    task automatic step(input string tag, input logic ack, input logic [9:0] exp);
        bus.mem_ack = ack;
        exp_q.push_back(exp);
        @(negedge clk);
        check(tag, 32'(outs()), 32'(exp_q.pop_front()));
        @(posedge clk);
        #1;
    endtask
    task automatic run_instr(input logic [15:0] ins, input logic skip, input logic zero, input logic neg, input int w);
        logic [3:0] op;
        op = ins[15:12];
        instruction = ins;
        skipstatus = skip;
        acc_zero = zero;
        acc_neg = neg;
        for (int i = 0; i < w; i++) step("fetch_wait", 1'b0, REQ);
        step("fetch_ack", 1'b1, REQ | IR | PCI);
        skipstatus = 1'b0;
        if (op < 4'h4) begin
            if (skip) begin
                step("exec1_skip", 1'b1, E1);
            end else begin
                for (int i = 0; i < w; i++) step("exec1_wait", 1'b0, REQ | AS | (op == 4'h1 ? WR : 10'h0));
                step("exec1_ack", 1'b1, REQ | AS | E1 | (op == 4'h1 ? WR : 10'h0));
            end
            if (op != 4'h1) step("exec2", 1'b0, E2 | (skip ? 10'h0 : AE));
        end else begin
            step("exec1", 1'b0, E1
                | ((!skip && (op == 4'h4 || (op == 4'h5 && neg) || (op == 4'h6 && zero))) ? PL : 10'h0)
                | ((!skip && op >= 4'h8 && op <= 4'hA) ? AE : 10'h0));
        end
        exp_cnt++;
        check("instr_count", 32'(instr_count), 32'(exp_cnt));
    endtask
    task automatic kick();
        start = 1'b1;
        step(halted ? "start_halt" : "start_idle", 1'b0, halted ? HL : 10'h0);
        start = 1'b0;
    endtask
    initial begin
        bus.mem_ack = 1'b0;
        #1;
        check("reset_outs", 32'(outs()), 32'h0);
        check("reset_cnt", 32'(instr_count), 32'h0);
        #13;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        step("idle_no_start", 1'b0, 10'h0);
        kick();
        run_instr(16'h0005, 1'b0, 1'b0, 1'b0, 0);
        run_instr(16'h7000, 1'b0, 1'b0, 1'b0, 0);
        step("halt_hold", 1'b1, HL);
        check("halt_cnt", 32'(instr_count), 32'd2);
        kick();
        run_instr(16'h2011, 1'b0, 1'b0, 1'b0, 3);
        run_instr(16'h6010, 1'b0, 1'b1, 1'b0, 0);
        run_instr(16'h6010, 1'b0, 1'b0, 1'b0, 1);
        run_instr(16'h5010, 1'b0, 1'b0, 1'b1, 0);
        run_instr(16'h5010, 1'b0, 1'b1, 1'b0, 0);
        run_instr(16'h4123, 1'b0, 1'b0, 1'b0, 2);
        run_instr(16'h1020, 1'b0, 1'b0, 1'b0, 1);
        run_instr(16'h1020, 1'b1, 1'b0, 1'b0, 0);
        run_instr(16'h3004, 1'b1, 1'b0, 1'b0, 0);
        run_instr(16'h4000, 1'b1, 1'b0, 1'b0, 0);
        run_instr(16'h9000, 1'b0, 1'b0, 1'b0, 0);
        run_instr(16'hA000, 1'b1, 1'b0, 1'b0, 0);
        run_instr(16'hB000, 1'b0, 1'b0, 1'b0, 0);
        run_instr(16'hC123, 1'b0, 1'b1, 1'b1, 0);
        run_instr(16'h7000, 1'b1, 1'b0, 1'b0, 0);
        check("skip_stp_no_halt", 32'(halted), 32'h0);
        instruction = 16'h0005;
        step("fetch_wait_rst", 1'b0, REQ);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_outs", 32'(outs()), 32'h0);
        check("async_rst_cnt", 32'(instr_count), 32'h0);
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step("idle_after_rst", 1'b1, 10'h0);
        step("idle_after_rst2", 1'b0, 10'h0);
        kick();
        while (exp_cnt != {CW{1'b1}}) run_instr(16'h8000, 1'b0, 1'b0, 1'b0, 0);
        check("cnt_max", 32'(instr_count), 32'(8'hFF));
        run_instr(16'h8000, 1'b0, 1'b0, 1'b0, 0);
        check("cnt_wrap", 32'(instr_count), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
